multicycle_control: RTL and testbench

//  Main sequencer for the multi-cycle MIPS core: a Moore FSM that steps shared datapath
//  (one ALU, one unified memory, IR/A/B/ALUOut latches) through fetch/decode/execute/mem/wb.

---
 rtl/mips_pkg.sv | 71 +++++++
 rtl/multicycle_control_if.sv | 38 +++
 rtl/mem_wait_timer.sv | 35 +++
 rtl/multicycle_control.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS control path: opcodes, datapath select codes,
// sequencer state encoding, trap causes and the control word.
package mips_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] ALU_SRC_B_B       = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_RWB    = 4'd7,
    ST_ADDIEX = 4'd8,
    ST_IWB    = 4'd9,
    ST_BRANCH = 4'd10,
    ST_JUMP   = 4'd11,
    ST_TRAP   = 4'd12
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_beq;
    logic       pc_write_bne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  // States that hold a memory request open and are guarded by the wait timer.
  function automatic logic is_mem_wait(state_e s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle between the multi-cycle sequencer and the shared datapath.
interface multicycle_control_if;
  import mips_pkg::*;

  logic [OP_W-1:0] opcode;
  logic            mem_ready;
  logic            pc_write;
  logic            pc_write_beq;
  logic            pc_write_bne;
  logic            iord;
  logic            mem_read;
  logic            mem_write;
  logic            ir_write;
  logic            reg_dst;
  logic            mem_to_reg;
  logic            reg_write;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [1:0]      alu_op;
  logic [1:0]      pc_source;
  logic            instr_done;
  logic            trap;
  logic [1:0]      trap_cause;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_beq, pc_write_bne, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           instr_done, trap, trap_cause
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_beq, pc_write_bne, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           instr_done, trap, trap_cause
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles; flags the wait that reaches the limit.
module mem_wait_timer #(
  parameter int unsigned TMR_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [TMR_W-1:0] limit,
  output logic             expired_c
);

  logic [TMR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + TMR_W'(1);
    end
  end

  // The wait being counted this cycle is the one that hits the limit.
  assign expired_c = inc && ((count_q + TMR_W'(1)) == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle MIPS core: steps the shared datapath through
// fetch/decode/execute/mem/writeback, stalls on memory and traps on faults.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TMR_W       = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);
  import mips_pkg::*;

  state_e     state_q, state_d;
  logic [1:0] trap_cause_q, trap_cause_d;
  logic       is_lw_q, is_lw_d;
  logic       is_bne_q, is_bne_d;
  logic       tmr_clear_c, tmr_inc_c, tmr_expired_c;
  ctrl_t      ctrl_c;

  assign tmr_inc_c   = is_mem_wait(state_q) && !bus.mem_ready;
  assign tmr_clear_c = is_mem_wait(state_d) && (state_d != state_q);

  mem_wait_timer #(.TMR_W(TMR_W)) u_timer (
    .clk       (clk),
    .rst_n     (reset),
    .clear     (tmr_clear_c),
    .inc       (tmr_inc_c),
    .limit     (TMR_W'(MEM_TIMEOUT)),
    .expired_c (tmr_expired_c)
  );

  // Next-state and control decode.
  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    is_lw_d      = is_lw_q;
    is_bne_d     = is_bne_q;
    ctrl_c       = '0;

    unique case (state_q)
      ST_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = ALU_SRC_B_FOUR;
        ctrl_c.alu_op    = ALU_OP_ADD;
        ctrl_c.pc_source = PC_SRC_ALU;
        // Held in reset, the fetch handshake must not load IR/PC.
        ctrl_c.ir_write  = bus.mem_ready & reset;
        ctrl_c.pc_write  = bus.mem_ready & reset;
        if (bus.mem_ready) begin
          state_d = ST_DECODE;
        end else if (tmr_expired_c) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_TIMEOUT;
        end
      end
      ST_DECODE: begin
        ctrl_c.alu_src_b = ALU_SRC_B_IMM_SH2;
        is_lw_d  = (bus.opcode == OP_LW);
        is_bne_d = (bus.opcode == OP_BNE);
        if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) begin
          state_d = ST_MEMADR;
        end else if (bus.opcode == OP_RTYPE) begin
          state_d = ST_EXEC;
        end else if (bus.opcode == OP_ADDI) begin
          state_d = ST_ADDIEX;
        end else if ((bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE)) begin
          state_d = ST_BRANCH;
        end else if (bus.opcode == OP_J) begin
          state_d = ST_JUMP;
        end else begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_ILLEGAL;
        end
      end
      ST_MEMADR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = ALU_SRC_B_IMM;
        state_d = is_lw_q ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.iord     = 1'b1;
        if (bus.mem_ready) begin
          state_d = ST_MEMWB;
        end else if (tmr_expired_c) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_TIMEOUT;
        end
      end
      ST_MEMWB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.instr_done = 1'b1;
        state_d = ST_FETCH;
      end
      ST_MEMWR: begin
        ctrl_c.mem_write  = 1'b1;
        ctrl_c.iord       = 1'b1;
        ctrl_c.instr_done = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = ST_FETCH;
        end else if (tmr_expired_c) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_TIMEOUT;
        end
      end
      ST_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = ALU_SRC_B_B;
        ctrl_c.alu_op    = ALU_OP_FUNCT;
        state_d = ST_RWB;
      end
      ST_RWB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.reg_dst    = 1'b1;
        ctrl_c.instr_done = 1'b1;
        state_d = ST_FETCH;
      end
      ST_ADDIEX: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = ALU_SRC_B_IMM;
        state_d = ST_IWB;
      end
      ST_IWB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.instr_done = 1'b1;
        state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        ctrl_c.alu_src_a    = 1'b1;
        ctrl_c.alu_op       = ALU_OP_SUB;
        ctrl_c.pc_source    = PC_SRC_ALUOUT;
        ctrl_c.pc_write_beq = !is_bne_q;
        ctrl_c.pc_write_bne = is_bne_q;
        ctrl_c.instr_done   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_JUMP: begin
        ctrl_c.pc_write   = 1'b1;
        ctrl_c.pc_source  = PC_SRC_JUMP;
        ctrl_c.instr_done = 1'b1;
        state_d = ST_FETCH;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_FETCH;
      trap_cause_q <= TRAP_NONE;
      is_lw_q      <= 1'b0;
      is_bne_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      trap_cause_q <= trap_cause_d;
      is_lw_q      <= is_lw_d;
      is_bne_q     <= is_bne_d;
    end
  end

  assign bus.pc_write     = ctrl_c.pc_write;
  assign bus.pc_write_beq = ctrl_c.pc_write_beq;
  assign bus.pc_write_bne = ctrl_c.pc_write_bne;
  assign bus.iord         = ctrl_c.iord;
  assign bus.mem_read     = ctrl_c.mem_read;
  assign bus.mem_write    = ctrl_c.mem_write;
  assign bus.ir_write     = ctrl_c.ir_write;
  assign bus.reg_dst      = ctrl_c.reg_dst;
  assign bus.mem_to_reg   = ctrl_c.mem_to_reg;
  assign bus.reg_write    = ctrl_c.reg_write;
  assign bus.alu_src_a    = ctrl_c.alu_src_a;
  assign bus.alu_src_b    = ctrl_c.alu_src_b;
  assign bus.alu_op       = ctrl_c.alu_op;
  assign bus.pc_source    = ctrl_c.pc_source;
  assign bus.instr_done   = ctrl_c.instr_done;
  assign bus.trap         = (state_q == ST_TRAP);
  assign bus.trap_cause   = trap_cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction phase recipes drive the
// inputs and predict the full control word every cycle, plus literal latencies.
module tb_multicycle_control;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_BNE   = 6'b000101;
  localparam logic [5:0] T_J     = 6'b000010;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [5:0] JUNK    = 6'b111111;

  typedef struct packed {
    logic       pcw, beq, bne, iord, mrd, mwr, irw, rdst, m2r, rw, asa;
    logic [1:0] asb, aop, psrc;
    logic       done, trap;
    logic [1:0] cause;
  } exp_t;

  typedef enum {
    PH_RESET, PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMRD, PH_MEMWB, PH_MEMWR,
    PH_EXEC, PH_RWB, PH_ADDIEX, PH_IWB, PH_BEQ, PH_BNE, PH_JUMP,
    PH_TRAP_ILL, PH_TRAP_TMO
  } phase_e;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if bus();

  multicycle_control #(.MEM_TIMEOUT(16), .TMR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t   exp_w;
  string  exp_name;
  logic   exp_valid = 1'b0;
  int     lat_exp   = 0;
  int     cyc_since = 0;
  int     vectors   = 0;
  int     misses    = 0;

  // What the datapath must see in each phase of an instruction, straight from the
  // control table; rdy is the mem_ready seen that cycle.
  function automatic exp_t phase_word(phase_e p, logic rdy);
    exp_t e = '0;
    case (p)
      PH_RESET:    begin e.mrd = 1'b1; e.asb = 2'b01; end
      PH_FETCH:    begin e.mrd = 1'b1; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy; end
      PH_DECODE:   begin e.asb = 2'b11; end
      PH_MEMADR:   begin e.asa = 1'b1; e.asb = 2'b10; end
      PH_MEMRD:    begin e.mrd = 1'b1; e.iord = 1'b1; end
      PH_MEMWB:    begin e.rw = 1'b1; e.m2r = 1'b1; e.done = 1'b1; end
      PH_MEMWR:    begin e.mwr = 1'b1; e.iord = 1'b1; e.done = rdy; end
      PH_EXEC:     begin e.asa = 1'b1; e.asb = 2'b00; e.aop = 2'b10; end
      PH_RWB:      begin e.rw = 1'b1; e.rdst = 1'b1; e.done = 1'b1; end
      PH_ADDIEX:   begin e.asa = 1'b1; e.asb = 2'b10; end
      PH_IWB:      begin e.rw = 1'b1; e.done = 1'b1; end
      PH_BEQ:      begin e.asa = 1'b1; e.aop = 2'b01; e.psrc = 2'b01; e.beq = 1'b1; e.done = 1'b1; end
      PH_BNE:      begin e.asa = 1'b1; e.aop = 2'b01; e.psrc = 2'b01; e.bne = 1'b1; e.done = 1'b1; end
      PH_JUMP:     begin e.pcw = 1'b1; e.psrc = 2'b10; e.done = 1'b1; end
      PH_TRAP_ILL: begin e.trap = 1'b1; e.cause = 2'b01; end
      PH_TRAP_TMO: begin e.trap = 1'b1; e.cause = 2'b10; end
      default:     e = '0;
    endcase
    return e;
  endfunction

  // Single compare point, mid-cycle; also measures instruction length at instr_done.
  always @(negedge clk) begin
    exp_t act;
    act = {bus.pc_write, bus.pc_write_beq, bus.pc_write_bne, bus.iord, bus.mem_read,
           bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
           bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source, bus.instr_done,
           bus.trap, bus.trap_cause};
    if (exp_valid) begin
      vectors++;
      if (act !== exp_w) begin
        misses++;
        $display("FAIL %s t=%0t: got ctrl=%b, want %b", exp_name, $time, act, exp_w);
      end
    end
    if (!reset) begin
      cyc_since = 0;
    end else if (exp_valid) begin
      cyc_since++;
      if (bus.instr_done === 1'b1) begin
        if (lat_exp != 0) begin
          vectors++;
          if (cyc_since != lat_exp) begin
            misses++;
            $display("FAIL latency t=%0t: got %0d cycles, want %0d", $time, cyc_since, lat_exp);
          end
        end
        cyc_since = 0;
      end
    end
  end

  task automatic step(input phase_e p, input logic [5:0] op, input logic rdy);
    bus.opcode    = op;
    bus.mem_ready = rdy;
    exp_w         = phase_word(p, rdy);
    exp_name      = p.name();
    exp_valid     = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    lat_exp       = 0;
    bus.opcode    = JUNK;
    bus.mem_ready = 1'b1;
    reset         = 1'b0;
    exp_w         = phase_word(PH_RESET, 1'b0);
    exp_name      = "reset";
    exp_valid     = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset     = 1'b1;
    exp_valid = 1'b0;
  endtask

  // One instruction: fw fetch waits, mw data-memory waits, lat = hand-computed length.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int lat);
    lat_exp = lat;
    for (int i = 0; i < fw; i++) step(PH_FETCH, JUNK, 1'b0);
    step(PH_FETCH, JUNK, 1'b1);
    step(PH_DECODE, op, 1'b1);
    case (op)
      T_RTYPE: begin step(PH_EXEC, JUNK, 1'b0); step(PH_RWB, JUNK, 1'b1); end
      T_ADDI:  begin step(PH_ADDIEX, JUNK, 1'b1); step(PH_IWB, JUNK, 1'b0); end
      T_BEQ:   step(PH_BEQ, JUNK, 1'b1);
      T_BNE:   step(PH_BNE, JUNK, 1'b0);
      T_J:     step(PH_JUMP, JUNK, 1'b1);
      T_LW: begin
        step(PH_MEMADR, JUNK, 1'b1);
        for (int i = 0; i < mw; i++) step(PH_MEMRD, JUNK, 1'b0);
        step(PH_MEMRD, JUNK, 1'b1);
        step(PH_MEMWB, JUNK, 1'b0);
      end
      T_SW: begin
        step(PH_MEMADR, JUNK, 1'b1);
        for (int i = 0; i < mw; i++) step(PH_MEMWR, JUNK, 1'b0);
        step(PH_MEMWR, JUNK, 1'b1);
      end
      default: ;
    endcase
  endtask

  initial begin
    bus.opcode    = JUNK;
    bus.mem_ready = 1'b0;
    do_reset();

    run_instr(T_RTYPE, 0, 0, 4);
    run_instr(T_LW,    0, 2, 7);
    run_instr(T_BEQ,   0, 0, 3);
    run_instr(T_BNE,   0, 0, 3);
    run_instr(T_J,     0, 0, 3);
    run_instr(T_ADDI,  0, 0, 4);
    run_instr(T_SW,    1, 3, 8);
    // Waits split across two guarded states must not accumulate.
    run_instr(T_LW,   10, 10, 25);
    // mem_ready arrives on the cycle that would be the 16th wait.
    run_instr(T_J,    15, 0, 18);

    // Illegal opcode, then a long sticky trap with mem_ready toggling.
    lat_exp = 0;
    step(PH_FETCH, JUNK, 1'b1);
    step(PH_DECODE, JUNK, 1'b1);
    for (int i = 0; i < 20; i++) step(PH_TRAP_ILL, T_RTYPE, 1'(i));
    do_reset();

    // Fetch timeout after 16 consecutive waits.
    for (int i = 0; i < 16; i++) step(PH_FETCH, JUNK, 1'b0);
    for (int i = 0; i < 3; i++) step(PH_TRAP_TMO, T_J, 1'b1);
    do_reset();

    // Data-read timeout.
    step(PH_FETCH, JUNK, 1'b1);
    step(PH_DECODE, T_LW, 1'b1);
    step(PH_MEMADR, JUNK, 1'b0);
    for (int i = 0; i < 16; i++) step(PH_MEMRD, JUNK, 1'b0);
    for (int i = 0; i < 2; i++) step(PH_TRAP_TMO, JUNK, 1'b1);
    do_reset();

    run_instr(T_RTYPE, 0, 0, 4);

    // Reset lands mid-cycle while a store is waiting.
    step(PH_FETCH, JUNK, 1'b1);
    step(PH_DECODE, T_SW, 1'b1);
    step(PH_MEMADR, JUNK, 1'b1);
    step(PH_MEMWR, JUNK, 1'b0);
    step(PH_MEMWR, JUNK, 1'b0);
    do_reset();

    run_instr(T_ADDI, 0, 0, 4);
    run_instr(T_BNE,  2, 0, 5);

    exp_valid = 1'b0;
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
